// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: definitions shared by the instruction fetch stage.
// Holds the default reset PC, the exception vector, the ExcCode values and
// the IF/ID register layout with its bubble encoding.
// Optional feature macro used by the fetch unit: FETCH_PERF_CNT_EN.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // ExcCode values that can be tagged onto a fetched instruction
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exccode;
    logic        bd;
  } ifid_t;

  // A bubble is an all-zero slot: nop instruction, pc 0, no exception, no delay slot
  localparam ifid_t IFID_BUBBLE = '{instr: 32'd0, pc: 32'd0, exccode: EXC_NONE, bd: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory bus between the fetch stage and imem.
//   pc_o    : fetch address, driven by the fetch unit
//   instr_i : instruction word returned combinationally for pc_o
//   adel_i  : fetch address error flag returned combinationally for pc_o
// Modports: master = fetch unit side, slave = instruction memory side.
interface fetch_unit_if;

  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        adel_i;

  modport master (output pc_o, input instr_i, input adel_i);
  modport slave  (input pc_o, output instr_i, output adel_i);

endinterface

// File: rtl/fetch_unit_ifid.sv
// ifid_reg: IF/ID pipeline register with three actions.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low; clears to a bubble
//   hold   : keep the current contents
//   bubble : load the bubble encoding (wins over hold)
//   d      : slot captured when neither hold nor bubble is set
//   q      : current register contents
module ifid_reg
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // Flushes take priority so an exception can squash a frozen slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= IFID_BUBBLE;
    end else if (bubble) begin
      q <= IFID_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC selection and IF/ID register.
//   clk, reset        : clock and asynchronous active-low reset
//   imem              : instruction memory bus (pc_o out, instr_i/adel_i in)
//   stall_i           : hazard freeze of PC and IF/ID
//   redirect_i/_pc_i  : taken branch/jump resolved in D
//   d_is_jmp_i        : D-stage instruction is a branch/jump (marks delay slot)
//   eret_i/epc_i      : return from exception
//   exc_req_i         : enter the exception handler and flush
//   d_instr_o, d_pc_o, d_exccode_o, d_bd_o : IF/ID register contents
//   perf_fetch_o, perf_stall_o : only when FETCH_PERF_CNT_EN is defined
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = fetch_unit_pkg::EXC_VECTOR,
  parameter logic [4:0]  EXC_ADEL   = fetch_unit_pkg::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master imem,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        d_is_jmp_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        exc_req_i,
  output logic [31:0] d_instr_o,
  output logic [31:0] d_pc_o,
  output logic [4:0]  d_exccode_o,
  output logic        d_bd_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  import fetch_unit_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        ifid_hold;
  logic        ifid_bubble;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  // Exceptions beat a stall; eret and redirect only act on an unfrozen pipe
  always_comb begin
    pc_next = pc_q + 32'd4;
    if (exc_req_i) begin
      pc_next = EXC_VECTOR;
    end else if (stall_i) begin
      pc_next = pc_q;
    end else if (eret_i) begin
      pc_next = epc_i;
    end else if (redirect_i) begin
      pc_next = redirect_pc_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign imem.pc_o = pc_q;

  // A redirect does not flush: the delay slot being fetched must still execute
  assign ifid_hold   = stall_i & ~exc_req_i;
  assign ifid_bubble = exc_req_i | (~stall_i & eret_i);

  // A faulting fetch carries its address and ExcCode but never the fetched word
  always_comb begin
    ifid_d.instr   = imem.instr_i;
    ifid_d.pc      = pc_q;
    ifid_d.exccode = EXC_NONE;
    ifid_d.bd      = d_is_jmp_i;
    if (imem.adel_i) begin
      ifid_d.instr   = 32'd0;
      ifid_d.exccode = EXC_ADEL;
    end
  end

  ifid_reg u_ifid (
    .clk    (clk),
    .reset  (reset),
    .hold   (ifid_hold),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign d_instr_o   = ifid_q.instr;
  assign d_pc_o      = ifid_q.pc;
  assign d_exccode_o = ifid_q.exccode;
  assign d_bd_o      = ifid_q.bd;

`ifdef FETCH_PERF_CNT_EN
  logic ifid_load;
  assign ifid_load = ~ifid_hold & ~ifid_bubble;

  // Free-running counters; natural 32-bit overflow gives the wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_o <= 32'd0;
      perf_stall_o <= 32'd0;
    end else begin
      if (ifid_load) begin
        perf_fetch_o <= perf_fetch_o + 32'd1;
      end
      if (ifid_hold) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a transaction-level
// reference model and a simple instruction memory (misaligned PCs fault).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i, d_is_jmp_i, eret_i, exc_req_i;
  logic [31:0] redirect_pc_i, epc_i;
  logic [31:0] d_instr_o, d_pc_o;
  logic [4:0]  d_exccode_o;
  logic        d_bd_o;
  logic [31:0] perf_fetch_o, perf_stall_o;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] pf;
    logic [31:0] ps;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  logic [31:0] m_pc, m_instr, m_dpc, m_pf, m_ps;
  logic [4:0]  m_exc;
  logic        m_bd;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  fetch_unit_if imem ();
  assign imem.instr_i = imem_word(imem.pc_o);
  assign imem.adel_i  = |imem.pc_o[1:0];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .d_is_jmp_i    (d_is_jmp_i),
    .eret_i        (eret_i),
    .epc_i         (epc_i),
    .exc_req_i     (exc_req_i),
    .d_instr_o     (d_instr_o),
    .d_pc_o        (d_pc_o),
    .d_exccode_o   (d_exccode_o),
    .d_bd_o        (d_bd_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign perf_fetch_o = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("pc_o", imem.pc_o, e.pc);
    checkValue("d_instr_o", d_instr_o, e.instr);
    checkValue("d_pc_o", d_pc_o, e.dpc);
    checkValue("d_exccode_o", {27'd0, d_exccode_o}, {27'd0, e.exc});
    checkValue("d_bd_o", {31'd0, d_bd_o}, {31'd0, e.bd});
`ifdef FETCH_PERF_CNT_EN
    checkValue("perf_fetch_o", perf_fetch_o, e.pf);
    checkValue("perf_stall_o", perf_stall_o, e.ps);
`endif
  endtask

  task automatic checkReset();
    checkValue("reset pc_o", imem.pc_o, 32'h0000_3000);
    checkValue("reset d_instr_o", d_instr_o, 32'd0);
    checkValue("reset d_pc_o", d_pc_o, 32'd0);
    checkValue("reset d_exccode_o", {27'd0, d_exccode_o}, 32'd0);
    checkValue("reset d_bd_o", {31'd0, d_bd_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkValue("reset perf_fetch_o", perf_fetch_o, 32'd0);
    checkValue("reset perf_stall_o", perf_stall_o, 32'd0);
`endif
  endtask

  task automatic modelReset();
    m_pc = 32'h0000_3000; m_instr = 0; m_dpc = 0; m_exc = 0; m_bd = 0; m_pf = 0; m_ps = 0;
  endtask

  // Called at a falling edge; drives one cycle of inputs, records the expected
  // state after the next rising edge, and returns at the following falling edge.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic jmp, input logic er, input logic [31:0] epc,
                               input logic ex);
    exp_t e;
    logic [31:0] npc;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc; d_is_jmp_i = jmp;
    eret_i = er; epc_i = epc; exc_req_i = ex;
    if (ex) npc = 32'h0000_4180;
    else if (st) npc = m_pc;
    else if (er) npc = epc;
    else if (rd) npc = rpc;
    else npc = m_pc + 32'd4;
    if (ex || (!st && er)) begin
      m_instr = 0; m_dpc = 0; m_exc = 0; m_bd = 0;
    end else if (!st) begin
      m_dpc = m_pc;
      m_bd  = jmp;
      if (m_pc[1:0] != 2'b00) begin
        m_instr = 0; m_exc = 5'd4;
      end else begin
        m_instr = imem_word(m_pc); m_exc = 0;
      end
      m_pf = m_pf + 1;
    end
    if (st && !ex) m_ps = m_ps + 1;
    m_pc = npc;
    e = '{pc: m_pc, instr: m_instr, dpc: m_dpc, exc: m_exc, bd: m_bd, pf: m_pf, ps: m_ps};
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Entered at a falling edge; leaves reset released at a falling edge.
  task automatic doReset();
    reset = 1'b0;
    stall_i = 0; redirect_i = 0; redirect_pc_i = 0; d_is_jmp_i = 0;
    eret_i = 0; epc_i = 0; exc_req_i = 0;
    #1 checkReset();
    @(negedge clk);
    #1 checkReset();
    @(negedge clk);
    modelReset();
    reset = 1'b1;
  endtask

  // monitor: the DUT presents a new fetch state after every rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    logic [31:0] r;
    reset = 1'b0;
    @(negedge clk);
    doReset();

    // sequential fetch from the reset PC
    idle(4);
    // taken jump at 0x3010, delay slot marked
    applyStimulus(0, 1, 32'h0000_3100, 1, 0, 0, 0);
    idle(1);
    // three stall cycles with an ignored redirect in the middle
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h0000_3200, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // exception while stalled
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    // misaligned fetch at 0x3002
    applyStimulus(0, 1, 32'h0000_3002, 0, 0, 0, 0);
    idle(2);
    // exception return
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_3040, 0);
    idle(2);
    // PC wrap past 2^32
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      applyStimulus(($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0) ? (r | 32'd2) : (r & ~32'd3),
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 15) == 0),
                    $urandom & ~32'd3,
                    ($urandom_range(0, 19) == 0));
    end

    // reset in the middle of operation
    doReset();
    idle(3);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom & ~32'd3, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 15) == 0), $urandom & ~32'd3,
                    ($urandom_range(0, 19) == 0));
    end
    idle(2);

    n_total++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning the exception/interrupt handler entry address.
REQ-003 SHALL have parameter EXC_ADEL, default 5'd4, meaning the ExcCode for an instruction-fetch address error.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge only.
REQ-005 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port pc_o, output, 32 bits, the current fetch address driven to instruction memory.
REQ-007 SHALL have ports instr_i, input, 32 bits, and adel_i, input, 1 bit, the instruction word and fetch-address-error flag returned combinationally by instruction memory for pc_o.
REQ-008 SHALL have port stall_i, input, 1 bit, a hazard-unit freeze of PC and IF/ID.
REQ-009 SHALL have ports redirect_i, input, 1 bit, and redirect_pc_i, input, 32 bits, for a taken branch/jump resolved in D.
REQ-010 SHALL have port d_is_jmp_i, input, 1 bit, asserted when the D-stage instruction is a branch or jump.
REQ-011 SHALL have ports eret_i, input, 1 bit, and epc_i, input, 32 bits, for return from exception.
REQ-012 SHALL have port exc_req_i, input, 1 bit, the CP0 request to enter the handler and flush.
REQ-013 SHALL have outputs d_instr_o (32 bits), d_pc_o (32 bits), d_exccode_o (5 bits) and d_bd_o (1 bit), the IF/ID register contents.

Function
REQ-014 Next-PC priority SHALL be exc_req_i -> EXC_VECTOR; else stall_i -> hold; else eret_i -> epc_i; else redirect_i -> redirect_pc_i; else pc_o+4 (modulo 2^32).
REQ-015 exc_req_i SHALL override stall_i; eret_i and redirect_i SHALL have no effect while stall_i is 1.
REQ-016 When stall_i is 1 and exc_req_i is 0, the IF/ID register SHALL hold its value.
REQ-017 exc_req_i or eret_i (unstalled) SHALL load IF/ID with a bubble: instr 0, pc 0, exccode 0, bd 0.
REQ-018 Otherwise IF/ID SHALL capture instr_i and pc_o, with d_bd_o set to d_is_jmp_i; redirect SHALL NOT flush, because the delay slot executes.
REQ-019 When adel_i is 1 on capture, d_instr_o SHALL be 0, d_exccode_o SHALL be EXC_ADEL, and d_pc_o SHALL be the faulting pc_o; otherwise d_exccode_o SHALL be 0.
REQ-020 Latency SHALL be one cycle from pc_o to the IF/ID outputs, and one cycle from any control input to the new pc_o.

Reset
REQ-021 While reset is 0, pc_o SHALL be RESET_PC, IF/ID SHALL hold a bubble, and the perf counters SHALL be 0, regardless of clk.
REQ-022 Deassertion of reset mid-operation SHALL restart fetch at RESET_PC on the next edge, and the first IF/ID capture SHALL be RESET_PC.

Configuration
REQ-023 With FETCH_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_fetch_o and perf_stall_o.
REQ-024 perf_fetch_o SHALL count cycles capturing a non-bubble; perf_stall_o SHALL count cycles with stall_i=1 and exc_req_i=0; both SHALL wrap at 2^32.
REQ-025 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-026 The shared definitions header SHALL hold RESET_PC, EXC_VECTOR, the ExcCode constants and the bubble encoding.
REQ-027 The IF/ID register SHALL be a sub-module ifid_reg (hold, bubble, load); PC selection SHALL stay in fetch_unit.

Verification
REQ-028 The bench SHALL cover this scenario: reset low then released, no stalls -> pc_o 0x3000, 0x3004, 0x3008; d_pc_o trails by one cycle.
REQ-029 The bench SHALL cover this scenario: redirect_i=1, redirect_pc_i=0x3100, d_is_jmp_i=1 at pc_o 0x3010 -> the next pc_o is 0x3100, and 0x3010 is captured with d_bd_o=1.
REQ-030 The bench SHALL cover this scenario: stall_i=1 for 3 cycles plus redirect_i pulse -> pc_o and IF/ID frozen, redirect ignored, perf_stall_o +3.
REQ-031 The bench SHALL cover this scenario: exc_req_i=1 together with stall_i=1 -> next pc_o is 0x4180 and IF/ID is a bubble.
REQ-032 The bench SHALL cover this scenario: adel_i=1 at pc_o 0x3002 -> d_instr_o 0, d_exccode_o 4, d_pc_o 0x3002.
REQ-033 The bench SHALL cover this scenario: eret_i=1, epc_i=0x3040 -> next pc_o 0x3040 and IF/ID is a bubble.
